apb_protocol_checker: RTL and testbench

Synthesizable APB4 protocol checker for an N-slave APB segment. It sits passively on the bus beside the bridge and slave decoder. It tracks every transfer with a phase state machine and reports rule violations as registered error events with a code and address. It also keeps saturating error and transfer counters, so the rule set works in simulators without assertion support and on FPGA/emulation.

---
 rtl/apb_protocol_checker.sv | 249 ++++++++++++++++++++++++
 tb/tb_apb_protocol_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_protocol_checker.sv
// -----------------------------------------------------------------------------
// apb_protocol_checker
//
// Passive APB4 protocol checker for an N-slave APB segment. It follows every
// transfer with a two-state phase FSM (IDLE / ACCESS). Rule violations are
// reported one cycle after the offending edge as a registered error event
// that carries a code and the PADDR seen on that cycle. Saturating counters
// track erroneous cycles and completed transfers.
//
// Optional feature (compile-time macro APB_CHECK_TIMEOUT_EN):
//   When defined, a wait-state counter flags code 6 once per transfer after
//   TIMEOUT_CYCLES access cycles with PREADY low. When undefined, the
//   counter is not built and any number of wait states is legal.
//
// Violation codes (the lowest code wins when several fire in one cycle):
//   1 setup skipped (PENABLE high on first select)
//   2 setup re-issued while an access phase was expected
//   3 address/control/data changed during the access phase
//   4 more than one PSEL bit high
//   5 PENABLE high with no transfer in progress
//   6 wait-state timeout (only with APB_CHECK_TIMEOUT_EN)
//   7 read setup with non-zero PSTRB
//   8 PSEL dropped before the transfer completed
//
// Ports:
//   pclk        in   APB clock, rising edge
//   presetn     in   synchronous active-low reset
//   check_en    in   1 = report and count; 0 = track only
//   psel        in   [NUM_SLAVES-1:0] slave selects
//   penable     in   access-phase strobe
//   pwrite      in   transfer direction
//   paddr       in   [ADDR_WIDTH-1:0] address
//   pwdata      in   [DATA_WIDTH-1:0] write data
//   pstrb       in   [DATA_WIDTH/8-1:0] write strobes
//   pready      in   slave ready
//   pslverr     in   slave error (not a protocol rule)
//   err_valid   out  one-cycle error pulse
//   err_code    out  [3:0] violation code, held until next pulse
//   err_addr    out  [ADDR_WIDTH-1:0] PADDR of the offending cycle
//   err_count   out  [CNT_WIDTH-1:0] saturating erroneous-cycle count
//   xfer_count  out  [CNT_WIDTH-1:0] saturating completed-transfer count
// -----------------------------------------------------------------------------
module apb_protocol_checker #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    check_en,
  input  logic [NUM_SLAVES-1:0]   psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic                    err_valid,
  output logic [3:0]              err_code,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [CNT_WIDTH-1:0]    xfer_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   done_q, done_d;

  // Transfer captures taken in the setup phase
  logic [NUM_SLAVES-1:0]   sel_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;

  logic                    err_valid_q;
  logic [3:0]              err_code_q;
  logic [ADDR_WIDTH-1:0]   err_addr_q;
  logic [CNT_WIDTH-1:0]    err_count_q;
  logic [CNT_WIDTH-1:0]    xfer_count_q;

  logic       sel_any;
  logic       is_setup;
  logic       multi_sel;
  logic       mismatch;
  logic       capture;
  logic       xfer_done;
  logic       waiting;
  logic [8:1] viol;
  logic [3:0] code;
  logic       report;

  // pslverr is a slave response, not a protocol rule; every PREADY in the
  // access phase counts as a completed transfer whatever its value.
  logic unused_pslverr;
  assign unused_pslverr = pslverr;

  assign sel_any   = |psel;
  assign is_setup  = sel_any && !penable;
  assign multi_sel = $countones(psel) > 1;
  assign waiting   = (state_q == ACCESS) && sel_any && penable && !pready;

  // Write data is only compared for write transfers
  assign mismatch = (psel != sel_q) || (paddr != addr_q) ||
                    (pwrite != write_q) || (pstrb != strb_q) ||
                    (write_q && (pwdata != wdata_q));

`ifdef APB_CHECK_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_hit;

  // Fires only on the transition into the limit; the counter then holds at
  // TIMEOUT_CYCLES so the pulse is produced once per transfer.
  assign timeout_hit = waiting && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_d = wait_q;
    if (capture) begin
      wait_d = '0;
    end else if (waiting && (wait_q != WAIT_W'(TIMEOUT_CYCLES))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic timeout_hit;
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0) && waiting;
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    capture   = 1'b0;
    xfer_done = 1'b0;
    viol      = '0;

    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          // Even a malformed start is tracked as a transfer so the FSM stays
          // in step with the bus.
          capture = 1'b1;
          state_d = ACCESS;
          if (penable) begin
            if (done_q) viol[5] = 1'b1;
            else        viol[1] = 1'b1;
          end
        end else if (penable) begin
          viol[5] = 1'b1;
        end
      end
      ACCESS: begin
        if (!sel_any) begin
          viol[8] = 1'b1;
          state_d = IDLE;
        end else if (!penable) begin
          viol[2] = 1'b1;
          capture = 1'b1;
        end else begin
          if (mismatch) viol[3] = 1'b1;
          if (pready) begin
            xfer_done = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (multi_sel)                      viol[4] = 1'b1;
    if (timeout_hit)                    viol[6] = 1'b1;
    if (is_setup && !pwrite && |pstrb)  viol[7] = 1'b1;
  end

  // Lowest active code wins: scan from the top so lower codes overwrite
  always_comb begin
    code = 4'd0;
    for (int i = 8; i >= 1; i--) begin
      if (viol[i]) code = 4'(i);
    end
  end

  assign report = check_en && (|viol);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_addr_q   <= '0;
      err_count_q  <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      err_valid_q <= report;
      if (report) begin
        err_code_q <= code;
        err_addr_q <= paddr;
        if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
      end
      if (check_en && xfer_done && (xfer_count_q != '1)) begin
        xfer_count_q <= xfer_count_q + 1'b1;
      end
    end
  end

  // NOTE: capture registers carry no reset; they are always written in the
  // setup phase before the access phase compares against them.
  always_ff @(posedge pclk) begin
    if (capture) begin
      sel_q   <= psel;
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
    end
  end

  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_addr   = err_addr_q;
  assign err_count  = err_count_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// -----------------------------------------------------------------------------
// tb_apb_protocol_checker
//
// Directed bench for apb_protocol_checker with default parameters. Inputs are
// driven 1 ns after a rising edge; outputs are sampled at that same point, so
// after each step() they reflect the cycle sampled at the edge just taken.
// Expected counter values are carried along by hand through the sequence.
// -----------------------------------------------------------------------------
module tb_apb_protocol_checker;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        check_en;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [15:0] err_addr;
  logic [7:0]  err_count;
  logic [7:0]  xfer_count;

  int vectors    = 0;
  int miscompares = 0;
  int err_seen   = 0;

  always #5 pclk = ~pclk;

  apb_protocol_checker dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .check_en   (check_en),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pready     (pready),
    .pslverr    (pslverr),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_addr   (err_addr),
    .err_count  (err_count),
    .xfer_count (xfer_count)
  );

  task automatic drive(input logic [3:0] sel, input logic en, input logic wr,
                       input logic [15:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic rdy);
    psel = sel; penable = en; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; pready = rdy;
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    if (err_valid === 1'b1) err_seen++;
  endtask

  task automatic test_reset();
    presetn = 1'b0; check_en = 1'b1; pslverr = 1'b0;
    idle();
    step(); step();
    vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", err_valid); end
    vectors++; if (err_code !== 4'd0) begin miscompares++; $display("FAIL reset_code got %0d want 0", err_code); end
    vectors++; if (err_addr !== 16'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0000", err_addr); end
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
    vectors++; if (xfer_count !== 8'd0) begin miscompares++; $display("FAIL reset_xfercnt got %0d want 0", xfer_count); end
    presetn = 1'b1;
    step();
  endtask

  // Write with 2 wait states, then back-to-back read with no idle bubble
  task automatic test_back_to_back();
    err_seen = 0;
    drive(4'b0010, 1'b0, 1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 1'b0); step();
    drive(4'b0010, 1'b1, 1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 1'b0); step(); step();
    pready = 1'b1; step();
    drive(4'b0010, 1'b0, 1'b0, 16'h0044, 32'h0, 4'h0, 1'b0); step();
    drive(4'b0010, 1'b1, 1'b0, 16'h0044, 32'h0, 4'h0, 1'b1); step();
    idle(); step();
    vectors++; if (err_seen !== 0) begin miscompares++; $display("FAIL b2b_no_err got %0d pulses want 0", err_seen); end
    vectors++; if (xfer_count !== 8'd2) begin miscompares++; $display("FAIL b2b_xfer got %0d want 2", xfer_count); end
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL b2b_errcnt got %0d want 0", err_count); end
  endtask

  task automatic test_setup_penable();
    drive(4'b0001, 1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b0); step();
    vectors++; if (err_valid !== 1'b1) begin miscompares++; $display("FAIL skip_setup_valid got %b want 1", err_valid); end
    vectors++; if (err_code !== 4'd1) begin miscompares++; $display("FAIL skip_setup_code got %0d want 1", err_code); end
    vectors++; if (err_addr !== 16'h0010) begin miscompares++; $display("FAIL skip_setup_addr got %h want 0010", err_addr); end
    vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL skip_setup_errcnt got %0d want 1", err_count); end
    pready = 1'b1; step();
    vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL skip_setup_pulse got %b want 0", err_valid); end
    vectors++; if (xfer_count !== 8'd3) begin miscompares++; $display("FAIL skip_setup_xfer got %0d want 3", xfer_count); end
    idle(); step();
    vectors++; if (err_code !== 4'd1) begin miscompares++; $display("FAIL code_hold got %0d want 1", err_code); end
  endtask

  task automatic test_addr_change();
    drive(4'b0001, 1'b0, 1'b0, 16'h0020, 32'h0, 4'h0, 1'b0); step();
    penable = 1'b1; step();
    paddr = 16'h0024; step();
    vectors++; if (err_valid !== 1'b1) begin miscompares++; $display("FAIL addr_chg_valid got %b want 1", err_valid); end
    vectors++; if (err_code !== 4'd3) begin miscompares++; $display("FAIL addr_chg_code got %0d want 3", err_code); end
    vectors++; if (err_addr !== 16'h0024) begin miscompares++; $display("FAIL addr_chg_addr got %h want 0024", err_addr); end
    vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL addr_chg_errcnt got %0d want 2", err_count); end
    paddr = 16'h0020; pready = 1'b1; step();
    vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL addr_chg_end got %b want 0", err_valid); end
    vectors++; if (xfer_count !== 8'd4) begin miscompares++; $display("FAIL addr_chg_xfer got %0d want 4", xfer_count); end
    idle(); step();
  endtask

  // Multi-select beats read-with-strobe; check_en=0 then masks the access
  task automatic test_multi_sel();
    drive(4'b0101, 1'b0, 1'b0, 16'h0030, 32'h0, 4'hF, 1'b0); step();
    vectors++; if (err_valid !== 1'b1) begin miscompares++; $display("FAIL multi_valid got %b want 1", err_valid); end
    vectors++; if (err_code !== 4'd4) begin miscompares++; $display("FAIL multi_code got %0d want 4", err_code); end
    vectors++; if (err_count !== 8'd3) begin miscompares++; $display("FAIL multi_errcnt got %0d want 3", err_count); end
    check_en = 1'b0; penable = 1'b1; pready = 1'b1; step();
    vectors++; if (err_valid !== 1'b0) begin miscompares++; $display("FAIL chk_dis_valid got %b want 0", err_valid); end
    vectors++; if (err_count !== 8'd3) begin miscompares++; $display("FAIL chk_dis_errcnt got %0d want 3", err_count); end
    vectors++; if (xfer_count !== 8'd4) begin miscompares++; $display("FAIL chk_dis_xfer got %0d want 4", xfer_count); end
    check_en = 1'b1; idle(); step();
  endtask

  task automatic test_codes();
    // Stray PENABLE while idle
    drive(4'b0000, 1'b1, 1'b0, 16'h0050, 32'h0, 4'h0, 1'b0); step();
    vectors++; if (err_code !== 4'd5 || err_valid !== 1'b1) begin miscompares++; $display("FAIL stray_en code %0d valid %b want 5/1", err_code, err_valid); end
    idle(); step();
    // PSEL dropped in access
    drive(4'b0001, 1'b0, 1'b0, 16'h0060, 32'h0, 4'h0, 1'b0); step();
    idle(); step();
    vectors++; if (err_code !== 4'd8 || err_count !== 8'd5) begin miscompares++; $display("FAIL drop code %0d cnt %0d want 8/5", err_code, err_count); end
    // Setup re-issued instead of access
    drive(4'b0001, 1'b0, 1'b0, 16'h0070, 32'h0, 4'h0, 1'b0); step();
    paddr = 16'h0074; step();
    vectors++; if (err_code !== 4'd2 || err_addr !== 16'h0074) begin miscompares++; $display("FAIL resetup code %0d addr %h want 2/0074", err_code, err_addr); end
    penable = 1'b1; pready = 1'b1; step();
    vectors++; if (err_valid !== 1'b0 || xfer_count !== 8'd5) begin miscompares++; $display("FAIL resetup_done valid %b xfer %0d want 0/5", err_valid, xfer_count); end
    // Read setup with strobes
    drive(4'b0001, 1'b0, 1'b0, 16'h0080, 32'h0, 4'h1, 1'b0); step();
    vectors++; if (err_code !== 4'd7 || err_count !== 8'd7) begin miscompares++; $display("FAIL rd_strb code %0d cnt %0d want 7/7", err_code, err_count); end
    penable = 1'b1; pready = 1'b1; step();
    // PENABLE on first select right after a completion reports 5, not 1
    drive(4'b0001, 1'b1, 1'b0, 16'h0090, 32'h0, 4'h0, 1'b0); step();
    vectors++; if (err_code !== 4'd5 || err_count !== 8'd8) begin miscompares++; $display("FAIL b2b_en code %0d cnt %0d want 5/8", err_code, err_count); end
    pready = 1'b1; step();
    vectors++; if (xfer_count !== 8'd7) begin miscompares++; $display("FAIL b2b_en_xfer got %0d want 7", xfer_count); end
    idle(); step();
  endtask

  task automatic test_wait_timeout();
    int pulses = 0;
    int pulse_at = 0;
    int exp_pulses;
    int exp_cnt;
    drive(4'b0001, 1'b0, 1'b0, 16'h00B0, 32'h0, 4'h0, 1'b0); step();
    penable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (err_valid === 1'b1) begin pulses++; pulse_at = i; end
    end
    pready = 1'b1; step();
`ifdef APB_CHECK_TIMEOUT_EN
    exp_pulses = 1; exp_cnt = 9;
    vectors++; if (pulse_at !== 16 || err_code !== 4'd6) begin miscompares++; $display("FAIL timeout_at cycle %0d code %0d want 16/6", pulse_at, err_code); end
`else
    exp_pulses = 0; exp_cnt = 8;
`endif
    vectors++; if (pulses !== exp_pulses) begin miscompares++; $display("FAIL timeout_pulses got %0d want %0d", pulses, exp_pulses); end
    vectors++; if (int'(err_count) !== exp_cnt) begin miscompares++; $display("FAIL timeout_errcnt got %0d want %0d", err_count, exp_cnt); end
    vectors++; if (xfer_count !== 8'd8) begin miscompares++; $display("FAIL timeout_xfer got %0d want 8", xfer_count); end
    idle(); step();
  endtask

  task automatic test_saturation();
    drive(4'b0000, 1'b1, 1'b0, 16'h00C0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 300; i++) step();
    vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL sat_errcnt got %0d want 255", err_count); end
    vectors++; if (err_valid !== 1'b1) begin miscompares++; $display("FAIL sat_valid got %b want 1", err_valid); end
    idle(); step();
    vectors++; if (err_count !== 8'd255 || err_valid !== 1'b0) begin miscompares++; $display("FAIL sat_hold cnt %0d valid %b want 255/0", err_count, err_valid); end
  endtask

  task automatic test_reset_mid();
    drive(4'b0001, 1'b0, 1'b1, 16'h00A0, 32'h12345678, 4'hF, 1'b0); step();
    penable = 1'b1; step();
    presetn = 1'b0; step();
    vectors++; if (err_valid !== 1'b0 || err_code !== 4'd0 || err_addr !== 16'h0) begin miscompares++; $display("FAIL rst_mid err valid %b code %0d addr %h want 0/0/0000", err_valid, err_code, err_addr); end
    vectors++; if (err_count !== 8'd0 || xfer_count !== 8'd0) begin miscompares++; $display("FAIL rst_mid cnt err %0d xfer %0d want 0/0", err_count, xfer_count); end
    presetn = 1'b1; idle(); err_seen = 0; step();
    drive(4'b1000, 1'b0, 1'b1, 16'h00A4, 32'hCAFEF00D, 4'h3, 1'b0); step();
    penable = 1'b1; pready = 1'b1; step();
    idle(); step();
    vectors++; if (err_seen !== 0) begin miscompares++; $display("FAIL rst_mid_spurious got %0d pulses want 0", err_seen); end
    vectors++; if (xfer_count !== 8'd1) begin miscompares++; $display("FAIL rst_mid_xfer got %0d want 1", xfer_count); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_setup_penable();
    test_addr_change();
    test_multi_sel();
    test_codes();
    test_wait_timeout();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
